// File: rtl/bird_ctrl.sv
// -----------------------------------------------------------------------------
// bird_ctrl -- controller for the bird column of the LED-matrix flappy-bird game.
//
// The block owns the bird's vertical position. It generates the gravity tick from
// a cycle counter and turns button edges into one-row flaps. It also detects pipe
// and ground collisions and counts the pipes that have passed.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   press      in   player button level (already synchronized)
//   pipe_col   in   [ROWS] pipe occupancy of the bird's column, bit i = row i blocked
//   pipe_pass  in   one-cycle pulse: a pipe column has just shifted past the bird
//   bird       out  [ROWS] one-hot bird row (row 0 = ground, ROWS-1 = top)
//   grav_tick  out  one-cycle pulse on each gravity event while playing
//   lose       out  high while the game is lost (global freeze)
//   playing    out  high while a game is in progress
//   score      out  [SCORE_W] pipes passed in the current or most recent game
// -----------------------------------------------------------------------------
module bird_ctrl #(
    parameter int ROWS        = 8,
    parameter int GRAV_PERIOD = 32,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               press,
    input  logic [ROWS-1:0]    pipe_col,
    input  logic               pipe_pass,
    output logic [ROWS-1:0]    bird,
    output logic               grav_tick,
    output logic               lose,
    output logic               playing,
    output logic [SCORE_W-1:0] score
);

    localparam int CNT_W = (GRAV_PERIOD > 2) ? $clog2(GRAV_PERIOD) : 1;

    localparam logic [ROWS-1:0]    ONE_ROW   = {{(ROWS-1){1'b0}}, 1'b1};
    localparam logic [ROWS-1:0]    HOME      = ONE_ROW << (ROWS/2);
    localparam logic [CNT_W-1:0]   TERM      = CNT_W'(GRAV_PERIOD - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [ROWS-1:0]    bird_nx;
    logic [SCORE_W-1:0] score_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               press_d;

    logic flap;   // rising edge of the button
    logic hit;    // bird overlaps a pipe this cycle
    logic term;   // gravity counter at its last count

    assign flap = press & ~press_d;
    assign hit  = |(bird & pipe_col);
    assign term = (cnt == TERM);

    // ------------------------------------------------------------------------
    // State register. press_d resets high so a button held through reset is
    // not taken as a press.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bird    <= HOME;
            score   <= '0;
            cnt     <= '0;
            press_d <= 1'b1;
        end else begin
            state   <= state_nx;
            bird    <= bird_nx;
            score   <= score_nx;
            cnt     <= cnt_nx;
            press_d <= press;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / next-position logic.
    // Bird updates are only shifts with end-stop guards or a reload of HOME.
    // This keeps bird one-hot by construction.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        bird_nx   = bird;
        score_nx  = score;
        cnt_nx    = cnt;
        grav_tick = 1'b0;

        unique case (state)
            IDLE: begin
                bird_nx = HOME;
                cnt_nx  = '0;
                if (flap) begin
                    state_nx = PLAY;
                    score_nx = '0;
                end
            end

            PLAY: begin
                if (hit) begin
                    // A collision freezes position, score and counter.
                    state_nx = LOST;
                end else begin
                    // Scoring runs in parallel with the movement below.
                    if (pipe_pass && (score != SCORE_MAX))
                        score_nx = score + 1'b1;

                    if (flap) begin
                        // A flap takes priority over a coincident terminal count.
                        // It restarts the gravity period.
                        cnt_nx = '0;
                        if (!bird[ROWS-1])
                            bird_nx = bird << 1;
                    end else if (term) begin
                        cnt_nx    = '0;
                        grav_tick = 1'b1;
                        if (bird[0])
                            state_nx = LOST;     // ground hit, bird stays at row 0
                        else
                            bird_nx = bird >> 1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end

            LOST: begin
                if (flap) begin
                    state_nx = IDLE;
                    bird_nx  = HOME;
                end
            end

            default: begin
                state_nx = IDLE;
                bird_nx  = HOME;
                cnt_nx   = '0;
            end
        endcase
    end

    assign lose    = (state == LOST);
    assign playing = (state == PLAY);

endmodule

// File: tb/tb_bird_ctrl.sv
module tb_bird_ctrl;

    localparam int ROWS        = 8;
    localparam int GRAV_PERIOD = 4;
    localparam int SCORE_W     = 4;
    localparam int SMAX        = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               press = 1'b1;
    logic [ROWS-1:0]    pipe_col = '0;
    logic               pipe_pass = 1'b0;
    logic [ROWS-1:0]    bird;
    logic               grav_tick;
    logic               lose;
    logic               playing;
    logic [SCORE_W-1:0] score;

    bird_ctrl #(.ROWS(ROWS), .GRAV_PERIOD(GRAV_PERIOD), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .reset(reset), .press(press), .pipe_col(pipe_col),
        .pipe_pass(pipe_pass), .bird(bird), .grav_tick(grav_tick),
        .lose(lose), .playing(playing), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROWS-1:0]    bird;
        logic               tick;
        logic               lose;
        logic               play;
        logic [SCORE_W-1:0] score;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   push_en = 0;

    // Reference model: game described as a row number and a mode.
    int m_mode;    // 0 = waiting, 1 = in game, 2 = game over
    int m_row;
    int m_cnt;
    int m_score;
    bit m_pd;

    // One stimulus cycle: drive inputs at negedge, queue the expected outputs
    // for this cycle, then advance the model across the coming posedge.
    task automatic cyc(input bit r, input bit p, input logic [ROWS-1:0] pc, input bit pp);
        exp_t e;
        bit   fl;
        bit   blocked;
        @(negedge clk);
        reset = r; press = p; pipe_col = pc; pipe_pass = pp;
        fl      = p && !m_pd;
        blocked = pc[m_row];
        e.bird  = ROWS'(1) << m_row;
        e.lose  = (m_mode == 2);
        e.play  = (m_mode == 1);
        e.score = SCORE_W'(m_score);
        e.tick  = (m_mode == 1) && !blocked && !fl && (m_cnt == GRAV_PERIOD - 1);
        if (push_en) q.push_back(e);
        if (r) begin
            m_mode = 0; m_row = ROWS/2; m_cnt = 0; m_score = 0; m_pd = 1;
        end else begin
            m_pd = p;
            if (m_mode == 0) begin
                m_row = ROWS/2; m_cnt = 0;
                if (fl) begin m_mode = 1; m_score = 0; end
            end else if (m_mode == 1) begin
                if (blocked) m_mode = 2;
                else begin
                    if (pp && m_score < SMAX) m_score++;
                    if (fl) begin
                        m_cnt = 0;
                        if (m_row < ROWS-1) m_row++;
                    end else if (m_cnt == GRAV_PERIOD - 1) begin
                        m_cnt = 0;
                        if (m_row == 0) m_mode = 2; else m_row--;
                    end else m_cnt++;
                end
            end else if (fl) begin
                m_mode = 0; m_row = ROWS/2;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0);
    endtask

    task automatic tap();
        cyc(0, 1, '0, 0);
        cyc(0, 0, '0, 0);
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bird !== e.bird) begin
                n_bad++; $display("FAIL bird: got %b want %b at %0t", bird, e.bird, $time);
            end
            n_cmp++;
            if (grav_tick !== e.tick) begin
                n_bad++; $display("FAIL grav_tick: got %b want %b at %0t", grav_tick, e.tick, $time);
            end
            n_cmp++;
            if (lose !== e.lose) begin
                n_bad++; $display("FAIL lose: got %b want %b at %0t", lose, e.lose, $time);
            end
            n_cmp++;
            if (playing !== e.play) begin
                n_bad++; $display("FAIL playing: got %b want %b at %0t", playing, e.play, $time);
            end
            n_cmp++;
            if (score !== e.score) begin
                n_bad++; $display("FAIL score: got %0d want %0d at %0t", score, e.score, $time);
            end
        end
    end

    initial begin
        logic [ROWS-1:0] gap;
        int budget;
        // Reset with the button held; outputs are unknown before the first edge.
        cyc(1, 1, '0, 0);
        push_en = 1;
        cyc(1, 1, '0, 0);
        // Held through reset and beyond: must stay waiting.
        cyc(0, 1, '0, 0); cyc(0, 1, '0, 0); cyc(0, 1, '0, 0);
        cyc(0, 0, '0, 0);
        tap();                                   // start game
        // Gravity down to the ground and the ground hit.
        idle(24);
        tap();                                   // back to waiting
        tap();                                   // new game
        for (int i = 0; i < 6; i++) tap();       // climb and saturate at top
        idle(8);
        for (int i = 0; i < 10; i++) cyc(0, 1, '0, 0);   // held press: one flap
        cyc(0, 0, '0, 0);
        // Flap on the terminal count.
        budget = 0;
        while (m_cnt != GRAV_PERIOD - 1 && budget < 10) begin cyc(0, 0, '0, 0); budget++; end
        cyc(0, 1, '0, 0);
        idle(5);
        // Scoring through gaps, then collision together with a flap edge.
        for (int i = 0; i < 3; i++) begin
            gap = ~(ROWS'(1) << m_row);
            cyc(0, 0, gap, 1);
        end
        cyc(0, 0, '0, 0);
        cyc(0, 1, ROWS'(1) << m_row, 0);
        cyc(0, 0, '0, 0);
        idle(3);
        tap();                                   // back to waiting, score kept
        tap();                                   // new game, score cleared
        idle(3);
        cyc(1, 0, '0, 0);                        // reset mid-game
        idle(2);
        // Score saturation: stay airborne while pipes pass every cycle.
        tap();
        for (int i = 0; i < 40; i++) cyc(0, i % 2 == 0, '0, 1);
        idle(2);
        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            logic [ROWS-1:0] pc;
            pc = '0;
            if ($urandom_range(0, 9) == 0) pc[$urandom_range(0, ROWS-1)] = 1'b1;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, pc,
                $urandom_range(0, 3) == 0);
        end
        // Drain the scoreboard with a bounded wait.
        budget = 0;
        while (q.size() > 0 && budget < 10) begin @(negedge clk); budget++; end
        #5;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
